// File: rtl/add_sub_seq_nbit_if.sv
// rtl/add_sub_seq_nbit_if.sv - request/result bundle of the sequential add/sub unit
interface add_sub_seq_nbit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic             acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ack;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic             cf;
  logic             zf;
  logic             vf;
  logic             nf;

  modport master (
    output start, op, acc, a, b, ack,
    input  ready, valid, result, cf, zf, vf, nf
  );

  modport slave (
    input  start, op, acc, a, b, ack,
    output ready, valid, result, cf, zf, vf, nf
  );
endinterface

// File: rtl/add_sub_seq_nbit.sv
// rtl/add_sub_seq_nbit.sv - add/subtract folded into CHUNK-bit slices, one slice per clock
module add_sub_seq_nbit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                clk,
  input  logic                rstn,
  add_sub_seq_nbit_if.slave   bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [KW-1:0]    k;

  logic [WIDTH-1:0] result_q;
  logic             cf_q;
  logic             zf_q;
  logic             vf_q;
  logic             nf_q;

  logic                   last;
  logic [CHUNK:0]         slice;
  logic [WIDTH+CHUNK-1:0] work_cat;
  logic [WIDTH+CHUNK-1:0] opa_cat;
  logic [WIDTH+CHUNK-1:0] opb_cat;
  logic [WIDTH-1:0]       work_nx;
  logic                   cin_msb;

  // Operands shift right so the current slice always sits in the low CHUNK bits;
  // the working sum fills from the top so it is aligned after NCH slices.
  assign last     = (k == KLAST);
  assign slice    = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
  assign work_cat = {slice[CHUNK-1:0], work};
  assign work_nx  = work_cat[WIDTH+CHUNK-1:CHUNK];
  assign opa_cat  = {{CHUNK{1'b0}}, opa};
  assign opb_cat  = {{CHUNK{1'b0}}, opb};
  // On the last slice the low bits hold the original MSBs, so the carry into
  // the MSB falls out of the sum bit: s = a ^ b ^ cin.
  assign cin_msb  = opa[CHUNK-1] ^ opb[CHUNK-1] ^ slice[CHUNK-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    bus.ready = 1'b0;
    bus.valid = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.valid = 1'b1;
        if (bus.ack) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      opa      <= '0;
      opb      <= '0;
      work     <= '0;
      carry    <= 1'b0;
      k        <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      vf_q     <= 1'b0;
      nf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa   <= bus.acc ? result_q : bus.a;
            opb   <= bus.op ? ~bus.b : bus.b;
            carry <= bus.op;
            k     <= '0;
          end
        end
        RUN: begin
          opa   <= opa_cat[WIDTH+CHUNK-1:CHUNK];
          opb   <= opb_cat[WIDTH+CHUNK-1:CHUNK];
          work  <= work_nx;
          carry <= slice[CHUNK];
          k     <= k + KW'(1);
          if (last) begin
            result_q <= work_nx;
            cf_q     <= slice[CHUNK];
            zf_q     <= (work_nx == '0);
            vf_q     <= cin_msb ^ slice[CHUNK];
            nf_q     <= work_nx[WIDTH-1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.cf     = cf_q;
  assign bus.zf     = zf_q;
  assign bus.vf     = vf_q;
  assign bus.nf     = nf_q;
endmodule

// File: tb/tb_add_sub_seq_nbit.sv
// tb/tb_add_sub_seq_nbit.sv - directed bench for add_sub_seq_nbit at CHUNK=4 and CHUNK=1
module tb_add_sub_seq_nbit;
  logic clk = 1'b0;
  logic rstn4;
  logic rstn1;
  int   errors = 0;
  int   checks = 0;
  int   lat;

  always #5 clk = ~clk;

  add_sub_seq_nbit_if #(.WIDTH(8)) i4 ();
  add_sub_seq_nbit_if #(.WIDTH(8)) i1 ();

  add_sub_seq_nbit #(.WIDTH(8), .CHUNK(4)) dut4 (.clk(clk), .rstn(rstn4), .bus(i4.slave));
  add_sub_seq_nbit #(.WIDTH(8), .CHUNK(1)) dut1 (.clk(clk), .rstn(rstn1), .bus(i1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation on the CHUNK=4 unit; lat counts edges from the accepting edge.
  task automatic run4(input logic op, input logic acc, input logic [7:0] a, input logic [7:0] b,
                      output int lt);
    i4.start = 1'b1; i4.op = op; i4.acc = acc; i4.a = a; i4.b = b;
    @(negedge clk);
    i4.start = 1'b0; i4.a = 8'h5A; i4.b = 8'hC3;
    lt = 1;
    while (!i4.valid && lt < 40) begin
      @(negedge clk);
      lt++;
    end
  endtask

  task automatic ack4;
    i4.ack = 1'b1;
    @(negedge clk);
    i4.ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn4 = 1'b0; rstn1 = 1'b0;
    i4.start = 0; i4.op = 0; i4.acc = 0; i4.a = 0; i4.b = 0; i4.ack = 0;
    i1.start = 0; i1.op = 0; i1.acc = 0; i1.a = 0; i1.b = 0; i1.ack = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", i4.ready, 1);
    chk("rst_valid", i4.valid, 0);
    chk("rst_result", i4.result, 8'h00);
    chk("rst_flags", {i4.cf, i4.zf, i4.vf, i4.nf}, 4'b0000);
    chk("rst1_ready", i1.ready, 1);
    rstn4 = 1'b1; rstn1 = 1'b1;
    @(negedge clk);

    // ACK while idle must not disturb anything
    ack4();
    chk("idle_ack_ready", i4.ready, 1);
    chk("idle_ack_valid", i4.valid, 0);

    run4(0, 0, 8'h7F, 8'h01, lat);
    chk("add7f_lat", lat, 3);
    chk("add7f_result", i4.result, 8'h80);
    chk("add7f_flags", {i4.cf, i4.zf, i4.vf, i4.nf}, 4'b0011);
    chk("add7f_ready", i4.ready, 0);
    ack4();
    chk("add7f_ack_ready", i4.ready, 1);
    chk("add7f_ack_valid", i4.valid, 0);

    run4(0, 0, 8'hFF, 8'h01, lat);
    chk("addff_result", i4.result, 8'h00);
    chk("addff_flags", {i4.cf, i4.zf, i4.vf, i4.nf}, 4'b1100);
    ack4();

    run4(1, 0, 8'h03, 8'h05, lat);
    chk("sub35_result", i4.result, 8'hFE);
    chk("sub35_flags", {i4.cf, i4.zf, i4.vf, i4.nf}, 4'b0001);
    ack4();

    run4(1, 0, 8'h80, 8'h01, lat);
    chk("sub80_result", i4.result, 8'h7F);
    chk("sub80_flags", {i4.cf, i4.zf, i4.vf, i4.nf}, 4'b1010);
    ack4();

    // reset together with START: reset wins, accumulator returns to 0
    rstn4 = 1'b0; i4.start = 1'b1;
    @(negedge clk);
    rstn4 = 1'b1; i4.start = 1'b0;
    chk("rst_start_ready", i4.ready, 1);
    chk("rst_start_result", i4.result, 8'h00);

    run4(0, 1, 8'hAA, 8'h10, lat);
    chk("acc1_result", i4.result, 8'h10);
    ack4();
    run4(0, 1, 8'hAA, 8'h10, lat);
    chk("acc2_result", i4.result, 8'h20);
    ack4();
    run4(0, 1, 8'hAA, 8'h10, lat);
    chk("acc3_result", i4.result, 8'h30);
    chk("acc3_flags", {i4.cf, i4.zf, i4.vf, i4.nf}, 4'b0000);
    ack4();
    run4(1, 1, 8'hAA, 8'h30, lat);
    chk("accsub_result", i4.result, 8'h00);
    chk("accsub_flags", {i4.cf, i4.zf, i4.vf, i4.nf}, 4'b1100);
    ack4();

    // START held through RUN and DONE, ACK withheld for 5 cycles
    i4.start = 1'b1; i4.op = 0; i4.acc = 0; i4.a = 8'h11; i4.b = 8'h22;
    @(negedge clk);
    i4.a = 8'h40; i4.b = 8'h40;
    lat = 1;
    while (!i4.valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", i4.valid, 1);
      chk("hold_result", i4.result, 8'h33);
      @(negedge clk);
    end
    i4.ack = 1'b1; i4.start = 1'b0;
    @(negedge clk);
    i4.ack = 1'b0;
    chk("hold_ack_ready", i4.ready, 1);
    chk("hold_ack_valid", i4.valid, 0);

    // reset on the edge after acceptance
    i4.start = 1'b1; i4.a = 8'h7F; i4.b = 8'h01;
    @(negedge clk);
    i4.start = 1'b0; rstn4 = 1'b0;
    @(negedge clk);
    rstn4 = 1'b1;
    chk("midrst_ready", i4.ready, 1);
    chk("midrst_valid", i4.valid, 0);
    chk("midrst_result", i4.result, 8'h00);
    chk("midrst_flags", {i4.cf, i4.zf, i4.vf, i4.nf}, 4'b0000);

    // CHUNK=1: eight slice cycles
    i1.start = 1'b1; i1.op = 0; i1.acc = 0; i1.a = 8'h7F; i1.b = 8'h01;
    @(negedge clk);
    i1.start = 1'b0; i1.a = 8'h00; i1.b = 8'h00;
    lat = 1;
    while (!i1.valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("c1_lat", lat, 9);
    chk("c1_result", i1.result, 8'h80);
    chk("c1_flags", {i1.cf, i1.zf, i1.vf, i1.nf}, 4'b0011);
    i1.ack = 1'b1;
    @(negedge clk);
    i1.ack = 1'b0;
    chk("c1_ack_ready", i1.ready, 1);

    i1.start = 1'b1; i1.op = 1; i1.a = 8'h03; i1.b = 8'h05;
    @(negedge clk);
    i1.start = 1'b0; rstn1 = 1'b0;
    @(negedge clk);
    rstn1 = 1'b1;
    chk("c1_midrst_ready", i1.ready, 1);
    chk("c1_midrst_valid", i1.valid, 0);
    chk("c1_midrst_result", i1.result, 8'h00);
    chk("c1_midrst_flags", {i1.cf, i1.zf, i1.vf, i1.nf}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
